// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : imem_pkg
// Brief   : Shared types, constants and the address check for the
//           instruction-memory responder.
// Revision: 1.0 - initial release
// ============================================================================
package imem_pkg;

  // Responder FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } imem_state_e;

  localparam int          WORD_BYTES  = 4;
  localparam logic [31:0] NOP_WORD    = 32'h0000_0000;

  // Counter holds LATENCY-1, so clog2 of the largest latency covers 0..3.
  localparam int          MAX_LATENCY = 4;
  localparam int          CNT_W       = $clog2(MAX_LATENCY);

  // True when a byte address is word aligned and its word index is in range.
  function automatic logic addr_ok(input logic [31:0] addr, input int depth);
    return ((addr % 32'(WORD_BYTES)) == 32'd0) &&
           ((addr / 32'(WORD_BYTES)) < $unsigned(depth));
  endfunction

endpackage
`default_nettype wire

// File: rtl/imem_array.sv
`default_nettype none
// ============================================================================
// Module  : imem_array
// Brief   : DEPTH_WORDS x 32 instruction store, one synchronous write port,
//           one registered read port with write-first forwarding.
// Revision: 1.0 - initial release
// ============================================================================
module imem_array #(
  parameter int DEPTH_WORDS = 4096,
  parameter int AW          = 12
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_idx,
  input  logic [31:0]   wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_idx,
  output logic [31:0]   rd_data
);

  logic [31:0] r_mem [DEPTH_WORDS];

  // Store write; contents deliberately survive reset so a loaded program persists.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      r_mem[wr_idx] <= wr_data;
    end
  end

  // Registered read; a same-cycle write to the read word wins over the old contents.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rd_data <= '0;
    end else if (rd_en) begin
      if (wr_en && (wr_idx == rd_idx)) begin
        rd_data <= wr_data;
      end else begin
        rd_data <= r_mem[rd_idx];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/imem_responder.sv
`default_nettype none
// ============================================================================
// Module  : imem_responder
// Brief   : Memory side of the instruction fetch interface. Accepts one word
//           fetch at a time, answers after LATENCY cycles with backpressure,
//           and exposes a program-load write port.
// Revision: 1.0 - initial release
// ============================================================================
module imem_responder
  import imem_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int LATENCY     = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_err,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  output logic        busy
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  imem_state_e      r_state;
  imem_state_e      w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [AW-1:0]    r_idx;
  logic             r_err;
  logic             r_resp_err;

  logic             w_accept;
  logic             w_rd_fire;
  logic             w_load_ok;
  logic [AW-1:0]    w_req_idx;
  logic [AW-1:0]    w_load_idx;
  logic [31:0]      w_rd_data;

  assign w_req_idx  = AW'(req_addr / 32'(WORD_BYTES));
  assign w_load_idx = AW'(load_addr / 32'(WORD_BYTES));
  assign w_load_ok  = load_en && addr_ok(load_addr, DEPTH_WORDS);

  // Error responses carry a zero word; the store output is masked rather than read.
  assign resp_data  = r_resp_err ? NOP_WORD : w_rd_data;
  assign resp_err   = r_resp_err;

  // FSM state register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake outputs; only IDLE accepts, only RESP presents data.
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    busy        = 1'b1;
    w_accept    = 1'b0;
    w_rd_fire   = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (r_cnt == '0) begin
          w_rd_fire   = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Request capture, latency countdown and error flag for the held response.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_cnt      <= '0;
      r_idx      <= '0;
      r_err      <= 1'b0;
      r_resp_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt <= CNT_W'(LATENCY - 1);
        r_idx <= w_req_idx;
        r_err <= !addr_ok(req_addr, DEPTH_WORDS);
      end else if ((r_state == WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_rd_fire) begin
        r_resp_err <= r_err;
      end
    end
  end

  imem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .CLK     (CLK),
    .RESET   (RESET),
    .wr_en   (w_load_ok),
    .wr_idx  (w_load_idx),
    .wr_data (load_data),
    .rd_en   (w_rd_fire && !r_err),
    .rd_idx  (r_idx),
    .rd_data (w_rd_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_imem_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_imem_responder
// Brief   : Self-checking bench for imem_responder. Four instances, LATENCY
//           1..4, share the load port and reset; lane 1 (LATENCY=2) carries
//           the directed tests.
// Revision: 1.0 - initial release
// ============================================================================
module tb_imem_responder;

  localparam int DEPTH = 4096;
  localparam int NLANE = 4;
  localparam int PRE   = 64;
  localparam int BOUND = 20;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  logic        req_valid_s  [NLANE];
  logic [31:0] req_addr_s   [NLANE];
  logic        resp_ready_s [NLANE];
  logic        req_ready_s  [NLANE];
  logic        resp_valid_s [NLANE];
  logic [31:0] resp_data_s  [NLANE];
  logic        resp_err_s   [NLANE];
  logic        busy_s       [NLANE];
  logic        load_en;
  logic [31:0] load_addr;
  logic [31:0] load_data;

  generate
    for (genvar gi = 0; gi < NLANE; gi++) begin : g_lane
      imem_responder #(
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (gi + 1)
      ) u_dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .req_valid  (req_valid_s[gi]),
        .req_ready  (req_ready_s[gi]),
        .req_addr   (req_addr_s[gi]),
        .resp_valid (resp_valid_s[gi]),
        .resp_ready (resp_ready_s[gi]),
        .resp_data  (resp_data_s[gi]),
        .resp_err   (resp_err_s[gi]),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .busy       (busy_s[gi])
      );
    end
  endgenerate

  // Reference model: plain word array plus the addressing rule.
  logic [31:0] model_mem [DEPTH];
  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] addr;
    int          hold;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;
  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic model_err(input logic [31:0] a);
    return ((a % 4) != 0) || ((a / 4) >= DEPTH);
  endfunction

  function automatic logic [31:0] model_data(input logic [31:0] a);
    if (model_err(a)) return 32'h0;
    return model_mem[a / 4];
  endfunction

  task automatic load_word(input logic [31:0] a, input logic [31:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    @(posedge CLK); #1;
    load_en   = 1'b0;
    if (!model_err(a)) model_mem[a / 4] = d;
  endtask

  // One complete fetch: request, measure latency, hold off for 'hold' cycles, handshake.
  task automatic fetch(input int l, input logic [31:0] a, input int hold, input string tag,
                       output logic [31:0] d, output logic e, output int gap);
    int t;
    req_valid_s[l]  = 1'b1;
    req_addr_s[l]   = a;
    resp_ready_s[l] = 1'b0;
    t = 0;
    while (!req_ready_s[l] && t < BOUND) begin
      @(posedge CLK); #1; t++;
    end
    @(posedge CLK); #1;
    req_valid_s[l] = 1'b0;
    req_addr_s[l]  = 32'h0;
    gap = 0;
    while (!resp_valid_s[l] && gap < BOUND) begin
      @(posedge CLK); #1; gap++;
    end
    d = resp_data_s[l];
    e = resp_err_s[l];
    for (int i = 0; i < hold; i++) begin
      check($sformatf("%s hold%0d resp_valid", tag, i), 32'(resp_valid_s[l]), 32'd1);
      check($sformatf("%s hold%0d req_ready", tag, i), 32'(req_ready_s[l]), 32'd0);
      check($sformatf("%s hold%0d data", tag, i), resp_data_s[l], d);
      @(posedge CLK); #1;
    end
    resp_ready_s[l] = 1'b1;
    @(posedge CLK); #1;
    resp_ready_s[l] = 1'b0;
    check($sformatf("%s post resp_valid", tag), 32'(resp_valid_s[l]), 32'd0);
    check($sformatf("%s post req_ready", tag), 32'(req_ready_s[l]), 32'd1);
  endtask

  // Fetch plus comparison of latency, data and error flag against the model.
  task automatic fetch_chk(input int l, input logic [31:0] a, input int hold, input string tag);
    logic [31:0] d;
    logic        e;
    int          gap;
    fetch(l, a, hold, tag, d, e, gap);
    check($sformatf("%s gap", tag), 32'(gap), 32'(l + 1));
    check($sformatf("%s data", tag), d, model_data(a));
    check($sformatf("%s err", tag), 32'(e), 32'(model_err(a)));
  endtask

  initial begin
    logic        saw_valid;
    logic [31:0] a;
    int          l;
    int          kind;

    RESET   = 1'b0;
    load_en = 1'b0;
    load_addr = 32'h0;
    load_data = 32'h0;
    for (int i = 0; i < NLANE; i++) begin
      req_valid_s[i]  = 1'b0;
      req_addr_s[i]   = 32'h0;
      resp_ready_s[i] = 1'b0;
    end
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;

    repeat (3) @(posedge CLK);
    #1;
    check("rst req_ready", 32'(req_ready_s[1]), 32'd1);
    check("rst resp_valid", 32'(resp_valid_s[1]), 32'd0);
    check("rst resp_data", resp_data_s[1], 32'h0);
    check("rst resp_err", 32'(resp_err_s[1]), 32'd0);
    check("rst busy", 32'(busy_s[1]), 32'd0);

    // Load while reset is still asserted: must be accepted.
    load_word(32'h0, 32'h1357_9BDF);
    RESET = 1'b1;

    for (int i = 1; i < PRE; i++) load_word(32'(4 * i), $urandom);
    load_word(32'h0C, 32'h2008_0005);
    load_word(32'h1C, 32'hAAAA_AAAA);
    load_word(32'(4 * (DEPTH - 1)), 32'h0BAD_F00D);
    load_word(32'h1, 32'hFFFF_FFFF);
    load_word(32'(4 * DEPTH), 32'hFFFF_FFFF);

    tbl[0] = '{32'h0C,               0, 32'h2008_0005, 1'b0};
    tbl[1] = '{32'h0C,               5, 32'h2008_0005, 1'b0};
    tbl[2] = '{32'h02,               0, 32'h0,         1'b1};
    tbl[3] = '{32'(4 * DEPTH),       0, 32'h0,         1'b1};
    tbl[4] = '{32'h00,               1, 32'h1357_9BDF, 1'b0};
    tbl[5] = '{32'h1C,               0, 32'hAAAA_AAAA, 1'b0};
    tbl[6] = '{32'hFFFF_FFFC,        2, 32'h0,         1'b1};
    tbl[7] = '{32'(4 * (DEPTH - 1)), 0, 32'h0BAD_F00D, 1'b0};

    for (int i = 0; i < 8; i++) begin
      logic [31:0] d;
      logic        e;
      int          gap;
      fetch(1, tbl[i].addr, tbl[i].hold, $sformatf("tbl%0d", i), d, e, gap);
      check($sformatf("tbl%0d gap", i), 32'(gap), 32'd2);
      check($sformatf("tbl%0d data", i), d, tbl[i].exp_data);
      check($sformatf("tbl%0d err", i), 32'(e), 32'(tbl[i].exp_err));
    end

    // Collision: load the word on the same edge the store is read.
    check("coll req_ready", 32'(req_ready_s[1]), 32'd1);
    req_valid_s[1] = 1'b1;
    req_addr_s[1]  = 32'h1C;
    @(posedge CLK); #1;
    req_valid_s[1] = 1'b0;
    @(posedge CLK); #1;
    load_en   = 1'b1;
    load_addr = 32'h1C;
    load_data = 32'h1234_5678;
    @(posedge CLK); #1;
    load_en = 1'b0;
    model_mem[7] = 32'h1234_5678;
    check("coll resp_valid", 32'(resp_valid_s[1]), 32'd1);
    check("coll resp_data", resp_data_s[1], 32'h1234_5678);
    check("coll resp_err", 32'(resp_err_s[1]), 32'd0);
    // A load to the same word while the response is held must not disturb it.
    load_word(32'h1C, 32'hDEAD_BEEF);
    check("resp-load held data", resp_data_s[1], 32'h1234_5678);
    resp_ready_s[1] = 1'b1;
    @(posedge CLK); #1;
    resp_ready_s[1] = 1'b0;
    check("coll done resp_valid", 32'(resp_valid_s[1]), 32'd0);

    // Reset in the middle of a WAIT, asserted between clock edges.
    req_valid_s[1] = 1'b1;
    req_addr_s[1]  = 32'h1C;
    @(posedge CLK); #1;
    req_valid_s[1] = 1'b0;
    check("midrst busy before", 32'(busy_s[1]), 32'd1);
    #2;
    RESET = 1'b0;
    #1;
    check("midrst resp_valid", 32'(resp_valid_s[1]), 32'd0);
    check("midrst busy", 32'(busy_s[1]), 32'd0);
    check("midrst req_ready", 32'(req_ready_s[1]), 32'd1);
    @(negedge CLK);
    RESET = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge CLK); #1;
      if (resp_valid_s[1]) saw_valid = 1'b1;
    end
    check("midrst no response", 32'(saw_valid), 32'd0);
    fetch_chk(1, 32'h1C, 0, "midrst mem kept");

    // Latency sweep: 20 sequential fetches per instance.
    for (int ln = 0; ln < NLANE; ln++) begin
      for (int i = 0; i < 20; i++) begin
        fetch_chk(ln, 32'(4 * i), 0, $sformatf("sweep L%0d w%0d", ln + 1, i));
      end
    end

    // Randomized fetches and loads against the model.
    for (int it = 0; it < 60; it++) begin
      l = int'($urandom_range(0, NLANE - 1));
      if ($urandom_range(0, 2) == 0) begin
        a = 32'(4 * $urandom_range(0, PRE - 1));
        if ($urandom_range(0, 3) == 0) a = a + 32'($urandom_range(1, 3));
        load_word(a, $urandom);
      end
      kind = int'($urandom_range(0, 9));
      if (kind < 6)      a = 32'(4 * $urandom_range(0, PRE - 1));
      else if (kind < 8) a = 32'(4 * $urandom_range(0, PRE - 1)) + 32'($urandom_range(1, 3));
      else               a = 32'(4 * DEPTH) + ($urandom & 32'h0FFF_FFFC);
      fetch_chk(l, a, int'($urandom_range(0, 3)), $sformatf("rand%0d", it));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder: the memory-side end of the instruction fetch interface.
- Accepts word-fetch requests from the fetch stage over a valid/ready handshake and returns the instruction word after a fixed, parameterised latency, with response backpressure.
- Provides a program-load write port so the testbench or boot logic can fill memory before and during execution.
- One request in flight at a time.

Parameters:
- DEPTH_WORDS, 4096, number of 32-bit words in the instruction store.
- LATENCY, 2, cycles from request acceptance to resp_valid assertion; legal range 1..4.

Ports:
- CLK  input  1  clock; all state changes on posedge.
- RESET  input  1  asynchronous, active-low reset.
- req_valid  input  1  fetch request present.
- req_ready  output  1  responder can accept a request.
- req_addr  input  32  byte address of the instruction.
- resp_valid  output  1  resp_data/resp_err are valid.
- resp_ready  input  1  fetch side accepts the response.
- resp_data  output  32  instruction word.
- resp_err  output  1  request was misaligned or out of range.
- load_en  input  1  write one word into the store this cycle.
- load_addr  input  32  byte address for the load.
- load_data  input  32  word to write.
- busy  output  1  high when state is not IDLE.

Behaviour:
- Clock and reset: one clock, CLK. Reset is RESET, asynchronous assert, active-low.
- Reset values:
  - state=IDLE, req_ready=1, resp_valid=0, resp_data=0, resp_err=0, busy=0, latency counter=0, captured address=0.
  - Memory contents are NOT reset.
- Addressing:
  - word index = addr>>2, so bits [1:0] are dropped for indexing.
  - A request is in error if addr[1:0]!=0 or index>=DEPTH_WORDS.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, capture addr and the error flag, load counter=LATENCY-1, go to WAIT.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle.
  - In the cycle where counter==0: read the store, register resp_data/resp_err, go to RESP.
  - Net effect: resp_valid rises exactly LATENCY cycles after the acceptance edge. With LATENCY=1, WAIT lasts one cycle.
- RESP:
  - resp_valid=1.
  - resp_data and resp_err are held stable until resp_ready is sampled high.
  - On handshake, resp_valid drops next cycle and the FSM returns to IDLE.
  - req_ready stays 0 in RESP; no same-cycle re-accept. Peak throughput is one fetch per LATENCY+2 cycles.
- Error response:
  - Uses the same latency.
  - resp_err=1 and resp_data=32'h00000000.
  - The store is not read.
- Load port:
  - Independent of the FSM and accepted in any state, including during reset deassertion.
  - Writes on posedge when load_en=1, load_addr[1:0]==0 and index<DEPTH_WORDS. Any other load is silently dropped.
- Load/read collision: if a load targets the same index on the same cycle the WAIT read occurs, resp_data returns load_data (write-first forwarding).
- A load to a word whose response is already in RESP does not alter the held resp_data.
- Reset mid-operation: an outstanding request is discarded and no response is produced. After RESET deasserts, the FSM is in IDLE.
- req_addr and req_valid are ignored outside IDLE. The requester must hold its request until req_ready is high.

Decomposition:
- Shared package imem_pkg:
  - state enum {IDLE, WAIT, RESP}.
  - WORD_BYTES=4.
  - NOP_WORD=32'h00000000, used as the error response data.
  - Latency-counter width derived by clog2 of the maximum LATENCY.
- One natural sub-module, imem_array:
  - DEPTH_WORDS x 32 storage.
  - One synchronous write port and one synchronous read port with write-first forwarding.
  - Bounds and alignment checks live in the responder.

Test Plan:
- Basic read: load word 3 with 32'h20080005; request 0x0C, LATENCY=2, resp_ready=1 → resp_valid rises 2 cycles after acceptance with resp_data=32'h20080005, resp_err=0; req_ready returns to 1 one cycle after the handshake.
- Backpressure: hold resp_ready=0 for 5 cycles during RESP → resp_valid stays 1 and resp_data stays stable; req_ready=0 throughout; completes on the cycle resp_ready=1.
- Errors:
  - Request 0x0000_0002 → resp_err=1, resp_data=0 at the same latency.
  - Request 4*DEPTH_WORDS → resp_err=1.
  - Load to 0x0000_0001 is dropped: a read of word 0 is unchanged.
- Collision: request word 7 holding 32'hAAAA_AAAA; on the WAIT read cycle, load word 7 with 32'h1234_5678 → resp_data=32'h1234_5678.
- Reset mid-operation: assert RESET low asynchronously, between clock edges, while in WAIT → resp_valid=0 and state=IDLE immediately; no response after release; memory contents preserved.
- LATENCY sweep 1..4: 20 back-to-back sequential fetches from 0x0 → every acceptance-to-valid gap equals LATENCY; data matches the preloaded words in order.
